// File: rtl/dmem_responder.sv
// Single-port data memory responder: one outstanding request, fixed response latency,
// byte/half/word accesses with sign/zero extension and error detection.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | request accepted, counting down remaining latency
  // RESP  | response presented, held until rsp_ready
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          err;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   load_v;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;

  assign req_ready = rst_n && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign word_idx  = req_addr[AW+1:2];
  assign rd_word   = mem[word_idx];

  always_comb begin
    err = 1'b0;
    case (req_op)
      OP_B:  err = 1'b0;
      OP_BU: err = req_we;
      OP_H:  err = req_addr[0];
      OP_HU: err = req_we || req_addr[0];
      OP_W:  err = (req_addr[1:0] != 2'b00);
      default: err = 1'b1;
    endcase
    if (req_addr[31:2] >= DEPTH_W) err = 1'b1;
  end

  always_comb begin
    byte_v = rd_word[8*req_addr[1:0] +: 8];
    half_v = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_v = 32'h0;
    case (req_op)
      OP_B:  load_v = {{24{byte_v[7]}}, byte_v};
      OP_BU: load_v = {24'h0, byte_v};
      OP_H:  load_v = {{16{half_v[15]}}, half_v};
      OP_HU: load_v = {16'h0, half_v};
      OP_W:  load_v = rd_word;
      default: load_v = 32'h0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone select the target.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = req_wdata;
    case (req_op)
      OP_B: begin
        be        = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      OP_H: begin
        be        = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      OP_W: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_err   <= err;
            rsp_rdata <= (err || req_we) ? 32'h0 : load_v;
            cnt       <= CNT_INIT;
            state     <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one LATENCY=1 instance driven from a vector table, one LATENCY=3
// instance for back-pressure and reset-during-wait sequences.
module tb_dmem_responder;
  localparam int DEPTH = 64;
  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_we = 1'b0;
  logic [2:0]  req_op = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_valid1 = 1'b0, req_valid3 = 1'b0;
  logic        rsp_ready1 = 1'b0, rsp_ready3 = 1'b0;
  logic        req_ready1, rsp_valid1, rsp_err1;
  logic        req_ready3, rsp_valid3, rsp_err3;
  logic [31:0] rsp_rdata1, rsp_rdata3;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1));

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  // One LATENCY=1 transaction: accept, response visible in the next cycle, consumed at once.
  task automatic run1(input vec_t v, input int idx);
    @(negedge clk);
    chk($sformatf("v%0d_req_ready_idle", idx), req_ready1, 1'b1);
    req_we = v.we; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
    req_valid1 = 1'b1; rsp_ready1 = 1'b1;
    @(negedge clk);
    req_valid1 = 1'b0;
    chk($sformatf("v%0d_rsp_valid", idx), rsp_valid1, 1'b1);
    chk($sformatf("v%0d_rsp_err", idx), rsp_err1, v.err);
    chk($sformatf("v%0d_rsp_rdata", idx), rsp_rdata1, v.rdata);
    chk($sformatf("v%0d_req_ready_resp", idx), req_ready1, 1'b0);
    @(negedge clk);
    chk($sformatf("v%0d_rsp_valid_done", idx), rsp_valid1, 1'b0);
  endtask

  task automatic start3(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata);
    @(negedge clk);
    req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    req_valid3 = 1'b1;
    @(negedge clk);
    req_valid3 = 1'b0;
  endtask

  task automatic wait_valid3(input string name);
    int n;
    n = 0;
    while (rsp_valid3 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid_timeout"}, rsp_valid3, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    vecs.push_back('{1'b1, OP_W,   32'h10,  32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, OP_W,   32'h10,  32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, OP_B,   32'h11,  32'h00000080, 32'h0,        1'b0});
    vecs.push_back('{1'b0, OP_B,   32'h11,  32'h0,        32'hFFFFFF80, 1'b0});
    vecs.push_back('{1'b0, OP_BU,  32'h11,  32'h0,        32'h00000080, 1'b0});
    vecs.push_back('{1'b0, OP_W,   32'h10,  32'h0,        32'hDEAD80EF, 1'b0});
    vecs.push_back('{1'b0, OP_H,   32'h13,  32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, OP_W,   32'h12,  32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, OP_BU,  32'h10,  32'h00000055, 32'h0,        1'b1});
    vecs.push_back('{1'b1, OP_HU,  32'h10,  32'h00005555, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, OP_W,   32'h100, 32'h12345678, 32'h0,        1'b1});
    vecs.push_back('{1'b0, OP_W,   32'h100, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, OP_W,   32'h10,  32'h0,        32'hDEAD80EF, 1'b0});
    vecs.push_back('{1'b1, OP_W,   32'h14,  32'h11223344, 32'h0,        1'b0});
    vecs.push_back('{1'b1, OP_H,   32'h16,  32'hFFFFABCD, 32'h0,        1'b0});
    vecs.push_back('{1'b0, OP_W,   32'h14,  32'h0,        32'hABCD3344, 1'b0});
    vecs.push_back('{1'b0, OP_H,   32'h16,  32'h0,        32'hFFFFABCD, 1'b0});
    vecs.push_back('{1'b0, OP_HU,  32'h16,  32'h0,        32'h0000ABCD, 1'b0});
    vecs.push_back('{1'b0, OP_H,   32'h14,  32'h0,        32'h00003344, 1'b0});
    vecs.push_back('{1'b0, OP_BU,  32'h17,  32'h0,        32'h000000AB, 1'b0});
    vecs.push_back('{1'b0, OP_B,   32'h15,  32'h0,        32'h00000033, 1'b0});
    vecs.push_back('{1'b1, OP_H,   32'h15,  32'h00000000, 32'h0,        1'b1});
    vecs.push_back('{1'b0, OP_W,   32'h14,  32'h0,        32'hABCD3344, 1'b0});

    // Reset values
    #2;
    chk("rst_req_ready1", req_ready1, 1'b0);
    chk("rst_rsp_valid1", rsp_valid1, 1'b0);
    chk("rst_rsp_rdata1", rsp_rdata1, 32'h0);
    chk("rst_rsp_err1", rsp_err1, 1'b0);
    chk("rst_req_ready3", req_ready3, 1'b0);
    chk("rst_rsp_valid3", rsp_valid3, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req_ready1", req_ready1, 1'b1);
    chk("post_rst_req_ready3", req_ready3, 1'b1);

    foreach (vecs[i]) run1(vecs[i], i);

    // LATENCY=3 with back-pressure
    rsp_ready3 = 1'b1;
    start3(1'b1, OP_W, 32'h20, 32'hCAFEF00D);
    wait_valid3("l3_prime");
    chk("l3_prime_err", rsp_err3, 1'b0);
    @(negedge clk);
    rsp_ready3 = 1'b0;
    start3(1'b0, OP_W, 32'h20, 32'h0);
    chk("l3_cycle1_valid", rsp_valid3, 1'b0);
    chk("l3_cycle1_ready", req_ready3, 1'b0);
    @(negedge clk);
    chk("l3_cycle2_valid", rsp_valid3, 1'b0);
    @(negedge clk);
    chk("l3_cycle3_valid", rsp_valid3, 1'b1);
    chk("l3_rdata", rsp_rdata3, 32'hCAFEF00D);
    chk("l3_err", rsp_err3, 1'b0);
    held = rsp_rdata3;
    for (int k = 0; k < 5; k++) begin
      req_valid3 = 1'b1; req_we = 1'b1; req_op = OP_W; req_addr = 32'h20; req_wdata = 32'h0;
      @(negedge clk);
      chk($sformatf("l3_hold%0d_valid", k), rsp_valid3, 1'b1);
      chk($sformatf("l3_hold%0d_rdata", k), rsp_rdata3, 32'hCAFEF00D);
      chk($sformatf("l3_hold%0d_ready", k), req_ready3, 1'b0);
    end
    req_valid3 = 1'b0;
    rsp_ready3 = 1'b1;
    @(negedge clk);
    chk("l3_consumed_valid", rsp_valid3, 1'b0);
    chk("l3_consumed_ready", req_ready3, 1'b1);
    // Store attempted while busy must not have landed
    start3(1'b0, OP_W, 32'h20, 32'h0);
    wait_valid3("l3_recheck");
    chk("l3_recheck_rdata", rsp_rdata3, held);
    @(negedge clk);

    // Reset during WAIT: response discarded, accepted store kept
    start3(1'b1, OP_W, 32'h24, 32'h0BADCAFE);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_valid", rsp_valid3, 1'b0);
    chk("rstw_ready", req_ready3, 1'b0);
    chk("rstw_rdata", rsp_rdata3, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstw_release_ready", req_ready3, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rstw_stale%0d", k), rsp_valid3, 1'b0);
    end
    start3(1'b0, OP_W, 32'h24, 32'h0);
    wait_valid3("rstw_load");
    chk("rstw_load_rdata", rsp_rdata3, 32'h0BADCAFE);
    chk("rstw_load_err", rsp_err3, 1'b0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 1024: number of 32-bit words of storage; power of two, at least 4.
REQ-002 Parameter LATENCY, default 1: cycles from request accept to rsp_valid; range 1..15.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset; asynchronous assert, active-low.
REQ-005 Port req_valid, input, 1: initiator presents a memory request.
REQ-006 Port req_ready, output, 1: responder can accept a request this cycle.
REQ-007 Port req_we, input, 1: 1 = store, 0 = load.
REQ-008 Port req_op, input, 3: access size/sign, mem_op_t encoding (b=000, h=001, w=011, bu=100, hu=101).
REQ-009 Port req_addr, input, 32: byte address.
REQ-010 Port req_wdata, input, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 Port rsp_valid, output, 1: response available.
REQ-012 Port rsp_ready, input, 1: initiator accepts the response.
REQ-013 Port rsp_rdata, output, 32: load result, right-aligned and extended; 0 for stores and errors.
REQ-014 Port rsp_err, output, 1: request was rejected (bad op, misaligned or out of range).

Function
REQ-015 A request is accepted in a cycle where req_valid and req_ready are both 1; at most one request is outstanding.
REQ-016 FSM states are IDLE, WAIT and RESP; req_ready = 1 only in IDLE.
REQ-017 IDLE transitions on accept: to RESP if LATENCY = 1, else to WAIT with the counter loaded to LATENCY-2.
REQ-018 WAIT decrements the counter each cycle and goes to RESP when the counter reaches 0.
REQ-019 rsp_valid = 1 only in RESP; the request accepted at edge T produces rsp_valid from edge T+LATENCY.
REQ-020 RESP holds rsp_valid, rsp_rdata and rsp_err stable until rsp_ready = 1, then goes to IDLE on that edge.
REQ-021 req_ready is 0 in the RESP cycle that completes; the next request can be accepted in the following cycle.
REQ-022 Word index = req_addr[log2(DEPTH)+1:2]; byte lane = req_addr[1:0].
REQ-023 Error conditions: req_op not one of the five legal codes.
REQ-024 Error conditions: a store with op bu or hu.
REQ-025 Error conditions: h/hu with addr[0] = 1, or w with addr[1:0] != 0.
REQ-026 Error condition: req_addr[31:2] >= DEPTH.
REQ-027 An erroring request never writes memory and returns rsp_err = 1 with rsp_rdata = 0.
REQ-028 Stores write memory at the accept edge using byte enables: b writes lane addr[1:0]; h writes lanes {addr[1],0} and {addr[1],1}; w writes all four lanes. Other bytes are unchanged.
REQ-029 Store data is replicated into the enabled lanes from req_wdata[7:0] (b) or req_wdata[15:0] (h).
REQ-030 A store returns rsp_err = 0 and rsp_rdata = 0.
REQ-031 Loads capture the addressed word at the accept edge and extract the result:
- b: selected byte, sign-extended
- bu: selected byte, zero-extended
- h: selected half, sign-extended
- hu: selected half, zero-extended
- w: the whole word
REQ-032 Request inputs are ignored outside IDLE; rsp_ready is ignored outside RESP.
REQ-033 A load immediately following a store to the same word returns the stored data.

Reset
REQ-034 While rst_n = 0 the FSM is IDLE and the counter is 0.
REQ-035 While rst_n = 0: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-036 req_ready goes to 1 in the first cycle after rst_n deasserts.
REQ-037 Reset during WAIT or RESP discards the outstanding response; a store already accepted remains written.
REQ-038 Memory contents are not initialised by reset.

Verification
REQ-039 LATENCY=1: store w 0xDEADBEEF to 0x10, then load w from 0x10 -> rsp_rdata = 0xDEADBEEF one cycle after accept, rsp_err = 0.
REQ-040 Store b 0x80 to 0x11, then load b / bu from 0x11 -> 0xFFFFFF80 / 0x00000080; word at 0x10 reads 0xDEAD80EF.
REQ-041 Error requests each return rsp_err = 1 and rsp_rdata = 0, with memory unchanged: load h from 0x13; load w from 0x12; store bu; req_op = 010; address 4*DEPTH.
REQ-042 LATENCY=3 with rsp_ready held 0 for 5 cycles -> rsp_valid rises 3 cycles after accept, outputs stay stable, req_ready stays 0 until the response is consumed.
REQ-043 Assert rst_n = 0 during WAIT -> rsp_valid = 0 immediately; after release req_ready = 1 and no stale response appears.
